// File: rtl/intersection_ctrl.sv
// intersection_ctrl: two-phase main/side street scheduler.
// Sequences green -> yellow -> all-red clearance for each street in turn,
// with per-state dwell timing from one shared timer. Main street holds
// green for at least GREEN_MIN cycles and yields only on side-street
// demand (car sensor or latched pedestrian request). The WALK lamp is lit
// during side green when a pedestrian request was captured for that phase.
module intersection_ctrl #(
  parameter int GREEN_MIN = 8,
  parameter int SIDE_T    = 6,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int TW        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic CAR_SIDE,
  input  logic PED_REQ,
  output logic MAIN_GRN,
  output logic MAIN_YLW,
  output logic MAIN_RED,
  output logic SIDE_GRN,
  output logic SIDE_YLW,
  output logic SIDE_RED,
  output logic WALK
);

  // Encodings 6 and 7 are unused and recover to S_MAIN_GO.
  typedef enum logic [2:0] {
    S_MAIN_GO     = 3'd0,
    S_MAIN_YLW    = 3'd1,
    S_CLR_TO_SIDE = 3'd2,
    S_SIDE_GO     = 3'd3,
    S_SIDE_YLW    = 3'd4,
    S_CLR_TO_MAIN = 3'd5
  } state_e;

  // Last timer value of each dwell; a state is left when the timer reaches it.
  localparam logic [TW-1:0] GREEN_LAST  = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] SIDE_LAST   = TW'(SIDE_T - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_T - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            ped_pend_q, ped_pend_d;
  logic            walk_flag_q, walk_flag_d;
  logic            demand;

  // Anything that should make main street give up green this cycle.
  assign demand = CAR_SIDE | ped_pend_q | PED_REQ;

  // Next-state, timer and pedestrian-latch logic.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + TW'(1);
    ped_pend_d  = ped_pend_q | PED_REQ;
    walk_flag_d = walk_flag_q;

    case (state_q)
      S_MAIN_GO: begin
        if (timer_q == GREEN_LAST) begin
          // Saturate so a late demand is served on the very next edge.
          timer_d = timer_q;
          if (demand) begin
            state_d = S_MAIN_YLW;
          end
        end
      end
      S_MAIN_YLW: begin
        if (timer_q == YELLOW_LAST) begin
          state_d = S_CLR_TO_SIDE;
        end
      end
      S_CLR_TO_SIDE: begin
        if (timer_q == ALLRED_LAST) begin
          state_d = S_SIDE_GO;
          // A request arriving on this very edge is served now, not re-latched.
          walk_flag_d = ped_pend_q | PED_REQ;
          ped_pend_d  = 1'b0;
        end
      end
      S_SIDE_GO: begin
        // Side green is fixed-length; the car sensor cannot extend it.
        if (timer_q == SIDE_LAST) begin
          state_d = S_SIDE_YLW;
        end
      end
      S_SIDE_YLW: begin
        if (timer_q == YELLOW_LAST) begin
          state_d = S_CLR_TO_MAIN;
        end
      end
      S_CLR_TO_MAIN: begin
        if (timer_q == ALLRED_LAST) begin
          state_d = S_MAIN_GO;
        end
      end
      default: begin
        state_d = S_MAIN_GO;
      end
    endcase

    // Every state change restarts the dwell timer.
    if (state_d != state_q) begin
      timer_d = '0;
    end
  end

  // State, timer and pedestrian registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_MAIN_GO;
      timer_q     <= '0;
      ped_pend_q  <= 1'b0;
      walk_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ped_pend_q  <= ped_pend_d;
      walk_flag_q <= walk_flag_d;
    end
  end

  // Lamp decode straight from the state register, one lamp per street.
  always_comb begin
    MAIN_GRN = 1'b0;
    MAIN_YLW = 1'b0;
    MAIN_RED = 1'b0;
    SIDE_GRN = 1'b0;
    SIDE_YLW = 1'b0;
    SIDE_RED = 1'b0;
    WALK     = 1'b0;
    case (state_q)
      S_MAIN_GO: begin
        MAIN_GRN = 1'b1;
        SIDE_RED = 1'b1;
      end
      S_MAIN_YLW: begin
        MAIN_YLW = 1'b1;
        SIDE_RED = 1'b1;
      end
      S_SIDE_GO: begin
        MAIN_RED = 1'b1;
        SIDE_GRN = 1'b1;
        WALK     = walk_flag_q;
      end
      S_SIDE_YLW: begin
        MAIN_RED = 1'b1;
        SIDE_YLW = 1'b1;
      end
      default: begin
        // Both clearance states and any unused encoding: all red.
        MAIN_RED = 1'b1;
        SIDE_RED = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl: directed checks of the intersection scheduler
// timing, pedestrian latch and reset abort, plus a random run checking
// the lamp safety properties.
module tb_intersection_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic CAR_SIDE = 1'b0;
  logic PED_REQ = 1'b0;
  logic MAIN_GRN, MAIN_YLW, MAIN_RED;
  logic SIDE_GRN, SIDE_YLW, SIDE_RED;
  logic WALK;

  int errors = 0;
  int checks = 0;

  // Lamp vector {MAIN_GRN,MAIN_YLW,MAIN_RED,SIDE_GRN,SIDE_YLW,SIDE_RED,WALK}
  localparam logic [6:0] L_MG  = 7'b1000010;
  localparam logic [6:0] L_MY  = 7'b0100010;
  localparam logic [6:0] L_CLR = 7'b0010010;
  localparam logic [6:0] L_SG  = 7'b0011000;
  localparam logic [6:0] L_SGW = 7'b0011001;
  localparam logic [6:0] L_SY  = 7'b0010100;

  logic [6:0] obs;
  assign obs = {MAIN_GRN, MAIN_YLW, MAIN_RED, SIDE_GRN, SIDE_YLW, SIDE_RED, WALK};

  intersection_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .CAR_SIDE (CAR_SIDE),
    .PED_REQ  (PED_REQ),
    .MAIN_GRN (MAIN_GRN),
    .MAIN_YLW (MAIN_YLW),
    .MAIN_RED (MAIN_RED),
    .SIDE_GRN (SIDE_GRN),
    .SIDE_YLW (SIDE_YLW),
    .SIDE_RED (SIDE_RED),
    .WALK     (WALK)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int cyc, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, o, e);
    end
  endtask

  // Leaves the bench in cycle 0 (first cycle after rst deasserts), at a negedge.
  task automatic do_reset();
    rst = 1'b1;
    CAR_SIDE = 1'b0;
    PED_REQ = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // CAR_SIDE held high: period-24 cycle.
  function automatic logic [6:0] exp_car(input int c);
    int m;
    m = c % 24;
    if (m < 8)       return L_MG;
    else if (m < 11) return L_MY;
    else if (m < 13) return L_CLR;
    else if (m < 19) return L_SG;
    else if (m < 22) return L_SY;
    else             return L_CLR;
  endfunction

  // Single PED_REQ at cycle 30 after main green has saturated.
  function automatic logic [6:0] exp_ped30(input int c);
    if (c < 31)      return L_MG;
    else if (c < 34) return L_MY;
    else if (c < 36) return L_CLR;
    else if (c < 42) return L_SGW;
    else if (c < 45) return L_SY;
    else if (c < 47) return L_CLR;
    else             return L_MG;
  endfunction

  // PED_REQ at cycle 0 and again at cycle 15 (inside side green).
  function automatic logic [6:0] exp_ped_twice(input int c);
    if (c < 8)       return L_MG;
    else if (c < 11) return L_MY;
    else if (c < 13) return L_CLR;
    else if (c < 19) return L_SGW;
    else if (c < 22) return L_SY;
    else if (c < 24) return L_CLR;
    else if (c < 32) return L_MG;
    else if (c < 35) return L_MY;
    else if (c < 37) return L_CLR;
    else if (c < 43) return L_SGW;
    else if (c < 46) return L_SY;
    else if (c < 48) return L_CLR;
    else             return L_MG;
  endfunction

  initial begin
    int my_run;
    int sy_run;

    // 1) Idle: no demand, main green forever.
    do_reset();
    check("reset_state", 0, 32'(obs), 32'(L_MG));
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      check("idle", c, 32'(obs), 32'(L_MG));
    end
    $display("idle phase done: checks=%0d errors=%0d", checks, errors);

    // 2) Car waiting from cycle 0.
    do_reset();
    CAR_SIDE = 1'b1;
    for (int c = 0; c < 50; c++) begin
      check("car_seq", c, 32'(obs), 32'(exp_car(c)));
      @(negedge clk);
    end
    $display("car sequence done: checks=%0d errors=%0d", checks, errors);

    // 3) One-cycle pedestrian request after saturation.
    do_reset();
    for (int c = 0; c < 60; c++) begin
      PED_REQ = (c == 30);
      check("ped30", c, 32'(obs), 32'(exp_ped30(c)));
      @(negedge clk);
    end
    PED_REQ = 1'b0;
    $display("late pedestrian done: checks=%0d errors=%0d", checks, errors);

    // 4) Request during side green carries into the next side phase.
    do_reset();
    for (int c = 0; c < 60; c++) begin
      PED_REQ = (c == 0) || (c == 15);
      check("ped_twice", c, 32'(obs), 32'(exp_ped_twice(c)));
      @(negedge clk);
    end
    PED_REQ = 1'b0;
    $display("repeat pedestrian done: checks=%0d errors=%0d", checks, errors);

    // 5) Reset in side green discards sequence and pending request.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      PED_REQ = (c == 0) || (c >= 12 && c <= 14);
      check("pre_abort", c, 32'(obs), 32'(exp_ped_twice(c)));
      if (c == 15) begin
        PED_REQ = 1'b0;
        rst = 1'b1;
      end
      @(negedge clk);
    end
    check("rst_abort", 16, 32'(obs), 32'(L_MG));
    rst = 1'b0;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      check("ped_forgotten", c, 32'(obs), 32'(L_MG));
    end
    $display("reset abort done: checks=%0d errors=%0d", checks, errors);

    // 6) Random traffic: safety, one lamp per street, yellow length.
    do_reset();
    my_run = 0;
    sy_run = 0;
    for (int c = 0; c < 10000; c++) begin
      CAR_SIDE = ($urandom_range(0, 3) == 0);
      PED_REQ  = ($urandom_range(0, 15) == 0);
      check("safety", c, 32'((MAIN_GRN | MAIN_YLW) & (SIDE_GRN | SIDE_YLW)), 32'd0);
      check("main_onehot", c, 32'($countones({MAIN_GRN, MAIN_YLW, MAIN_RED})), 32'd1);
      check("side_onehot", c, 32'($countones({SIDE_GRN, SIDE_YLW, SIDE_RED})), 32'd1);
      check("walk_in_side_green", c, 32'(WALK & ~SIDE_GRN), 32'd0);
      if (MAIN_YLW) begin
        my_run++;
      end else if (my_run != 0) begin
        check("main_yellow_len", c, 32'(my_run), 32'd3);
        my_run = 0;
      end
      if (SIDE_YLW) begin
        sy_run++;
      end else if (sy_run != 0) begin
        check("side_yellow_len", c, 32'(sy_run), 32'd3);
        sy_run = 0;
      end
      @(negedge clk);
    end
    CAR_SIDE = 1'b0;
    PED_REQ = 1'b0;
    $display("random traffic done: checks=%0d errors=%0d", checks, errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
